// File: rtl/fsm_interface_pkg.sv
// Shared types and constants for the AES-128 bus-side control FSM.
package fsm_interface_pkg;

    localparam int unsigned DefaultWords = 16;

    typedef enum logic [5:0] {
        IDLE    = 6'b000001,
        WR_MSG  = 6'b000010,
        WR_KEY  = 6'b000100,
        LOAD    = 6'b001000,
        RD      = 6'b010000,
        RD_DONE = 6'b100000
    } state_t;

    // Counter must be able to hold the value WORDS itself (saturation point).
    function automatic int unsigned cnt_width(input int unsigned words);
        return $clog2(words + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that saturates at Limit, with synchronous clear; only reports saturation.
module sat_counter #(
    parameter int unsigned Width = 5,
    parameter int unsigned Limit = 16
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic full_o
);

    localparam logic [Width-1:0] LimitW = Width'(Limit);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q < LimitW)) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign full_o = (cnt_q >= LimitW);

endmodule

// File: rtl/fsm_interface.sv
// Bus-side control FSM of the AES-128 core: decodes CS/RW/adress into one-hot
// Moore strobes for the message/key/result shift registers.
module fsm_interface
    import fsm_interface_pkg::*;
#(
    parameter int unsigned WORDS = DefaultWords
) (
    input  logic clk,
    input  logic reset,
    input  logic CS,
    input  logic RW,
    input  logic adress,
    output logic load,
    output logic shift_in_message,
    output logic shift_in_key,
    output logic shift_out
);

    localparam int unsigned CntW = cnt_width(WORDS);

    state_t state_q, state_d;

    logic msg_inc, key_inc, out_inc, cnt_clr;
    logic msg_full, key_full, out_full;

    always_comb begin
        state_d = state_q;
        msg_inc = 1'b0;
        key_inc = 1'b0;
        out_inc = 1'b0;
        cnt_clr = 1'b0;
        if (!CS) begin
            state_d = IDLE;
        end else if (RW) begin
            if (!adress) begin
                if (!msg_full) begin
                    state_d = WR_MSG;
                    msg_inc = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end else begin
                if (!key_full) begin
                    state_d = WR_KEY;
                    key_inc = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
        end else begin
            unique case (state_q)
                LOAD, RD: begin
                    if (!out_full) begin
                        state_d = RD;
                        out_inc = 1'b1;
                    end else begin
                        state_d = RD_DONE;
                    end
                end
                RD_DONE: state_d = RD_DONE;
                // Any read that does not continue a burst starts a fresh one.
                default: begin
                    state_d = LOAD;
                    cnt_clr = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    sat_counter #(
        .Width (CntW),
        .Limit (WORDS)
    ) u_msg_cnt (
        .clk_i   (clk),
        .reset_i (reset),
        .clr_i   (cnt_clr),
        .inc_i   (msg_inc),
        .full_o  (msg_full)
    );

    sat_counter #(
        .Width (CntW),
        .Limit (WORDS)
    ) u_key_cnt (
        .clk_i   (clk),
        .reset_i (reset),
        .clr_i   (cnt_clr),
        .inc_i   (key_inc),
        .full_o  (key_full)
    );

    sat_counter #(
        .Width (CntW),
        .Limit (WORDS)
    ) u_out_cnt (
        .clk_i   (clk),
        .reset_i (reset),
        .clr_i   (cnt_clr),
        .inc_i   (out_inc),
        .full_o  (out_full)
    );

    assign load             = (state_q == LOAD);
    assign shift_in_message = (state_q == WR_MSG);
    assign shift_in_key     = (state_q == WR_KEY);
    assign shift_out        = (state_q == RD);

endmodule

// File: tb/tb_fsm_interface.sv
// Self-checking bench for fsm_interface: directed test-plan steps followed by
// randomized bursts, all checked against a transaction-level reference model.
module tb_fsm_interface;

    localparam int unsigned W = 16;

    localparam int KNone  = 0;
    localparam int KMsg   = 1;
    localparam int KKey   = 2;
    localparam int KLoad  = 3;
    localparam int KShift = 4;
    localparam int KDone  = 5;
    localparam int KModel = -1;

    logic clk = 1'b0;
    logic reset, CS, RW, adress;
    logic load, shift_in_message, shift_in_key, shift_out;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: words accepted per block, and what the last cycle did.
    int m_msg  = 0;
    int m_key  = 0;
    int m_out  = 0;
    int m_last = KNone;

    fsm_interface #(
        .WORDS (W)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .CS               (CS),
        .RW               (RW),
        .adress           (adress),
        .load             (load),
        .shift_in_message (shift_in_message),
        .shift_in_key     (shift_in_key),
        .shift_out        (shift_out)
    );

    always #5 clk = ~clk;

    // Strobe vector ordering: {load, shift_in_message, shift_in_key, shift_out}.
    function automatic logic [3:0] kind_to_strobes(input int k);
        case (k)
            KLoad:   return 4'b1000;
            KMsg:    return 4'b0100;
            KKey:    return 4'b0010;
            KShift:  return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic model_step(input logic r, input logic c, input logic w, input logic a);
        if (r) begin
            m_msg  = 0;
            m_key  = 0;
            m_out  = 0;
            m_last = KNone;
        end else if (!c) begin
            m_last = KNone;
        end else if (w) begin
            if (!a) begin
                if (m_msg < W) begin
                    m_msg++;
                    m_last = KMsg;
                end else begin
                    m_last = KNone;
                end
            end else begin
                if (m_key < W) begin
                    m_key++;
                    m_last = KKey;
                end else begin
                    m_last = KNone;
                end
            end
        end else if (m_last == KDone) begin
            m_last = KDone;
        end else if (m_last == KLoad || m_last == KShift) begin
            if (m_out < W) begin
                m_out++;
                m_last = KShift;
            end else begin
                m_last = KDone;
            end
        end else begin
            m_msg  = 0;
            m_key  = 0;
            m_out  = 0;
            m_last = KLoad;
        end
    endtask

    // exp_kind = KModel takes the expectation from the reference model.
    task automatic step(input logic r, input logic c, input logic w, input logic a,
                        input int exp_kind, input string tag);
        logic [3:0] obs, exp;
        @(negedge clk);
        reset  = r;
        CS     = c;
        RW     = c ? w : 1'bx;
        adress = c ? a : 1'bx;
        @(posedge clk);
        model_step(r, c, w, a);
        #1;
        exp = (exp_kind == KModel) ? kind_to_strobes(m_last) : kind_to_strobes(exp_kind);
        obs = {load, shift_in_message, shift_in_key, shift_out};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b (ld,msg,key,out)", tag, obs, exp);
        end
    endtask

    initial begin
        logic c, w, a, r;
        int   len;

        reset  = 1'b1;
        CS     = 1'b0;
        RW     = 1'bx;
        adress = 1'bx;

        // 1. reset with CS low and X on RW/adress
        step(1'b1, 1'b0, 1'b0, 1'b0, KNone, "reset");
        step(1'b0, 1'b0, 1'b0, 1'b0, KNone, "idle_x_inputs");

        // 2. five message writes
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0, KMsg, "msg_burst");
        // 3. switch to key with no gap
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b1, KKey, "key_burst");
        // 4. read: one load then shift_out
        step(1'b0, 1'b1, 1'b0, 1'b0, KLoad, "read_load");
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 1'b0, KShift, "read_shift");
        step(1'b0, 1'b0, 1'b0, 1'b0, KNone, "deselect");

        // 5. message over-run saturates at W
        for (int i = 0; i < 20; i++)
            step(1'b0, 1'b1, 1'b1, 1'b0, (i < W) ? KMsg : KNone, "msg_overrun");

        // 6. full read burst then RD_DONE
        for (int i = 0; i < 20; i++)
            step(1'b0, 1'b1, 1'b0, 1'b0,
                 (i == 0) ? KLoad : ((i <= W) ? KShift : KDone), "read_overrun");

        // reset in the middle of a shift_out burst
        step(1'b0, 1'b0, 1'b0, 1'b0, KNone, "deselect2");
        step(1'b0, 1'b1, 1'b0, 1'b0, KLoad, "read2_load");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, KShift, "read2_shift");
        step(1'b1, 1'b1, 1'b0, 1'b0, KNone, "reset_mid_read");
        step(1'b0, 1'b1, 1'b0, 1'b0, KLoad, "read_after_reset");

        // randomized bursts against the reference model
        for (int b = 0; b < 80; b++) begin
            len = $urandom_range(1, 24);
            c   = ($urandom_range(0, 9) != 0);
            w   = 1'($urandom_range(0, 1));
            a   = 1'($urandom_range(0, 1));
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 7) == 0) a = ~a;
                r = ($urandom_range(0, 149) == 0);
                step(r, c, w, a, KModel, "random");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fsm_interface.md
Name: fsm_interface

Overview:
- Bus-side control FSM of the AES-128 core.
- Decodes chip-select, read/write and a 1-bit address into one-hot strobes:
  - shift a plaintext word into the message shift register;
  - shift a key word into the key shift register;
  - load the datapath / output register;
  - shift a result word out.
- Sits between the host bus and the datapath shift registers.
- Contains no data path; it only tracks word counts.

Parameters:
- WORDS, 16, number of bus words per 128-bit block (message, key and result each); must be ≥1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- CS  input  1  chip select; when 0, RW and adress are don't-care (X tolerated).
- RW  input  1  1 = host write, 0 = host read.
- adress  input  1  write target: 0 = message, 1 = key; ignored on reads.
- load  output  1  one-cycle strobe: transfer message/key to the core and capture the result into the output shift register.
- shift_in_message  output  1  shift one word into the message register this cycle.
- shift_in_key  output  1  shift one word into the key register this cycle.
- shift_out  output  1  shift one result word out this cycle.

Behaviour:
- One clock domain. Reset is synchronous and active-high. Ports are named clk and reset.
- Reset result: state IDLE, all counters 0, all outputs 0. Reset has priority over every other condition, including mid-transfer.
- Moore FSM. Outputs are decoded only from the state register, so a strobe appears one cycle after the sampling edge.
- States and outputs (at most one output high in any state):
  - IDLE → none.
  - WR_MSG → shift_in_message.
  - WR_KEY → shift_in_key.
  - LOAD → load.
  - RD → shift_out.
  - RD_DONE → none.
- Counters: msg_cnt, key_cnt, out_cnt, each $clog2(WORDS+1) bits. They saturate at WORDS and never wrap.
- Next state, evaluated every edge in priority order:
  1. CS=0 → IDLE. Counters hold.
  2. CS=1, RW=1, adress=0:
     - msg_cnt<WORDS → WR_MSG, msg_cnt+1;
     - otherwise → IDLE (excess write ignored).
  3. CS=1, RW=1, adress=1:
     - key_cnt<WORDS → WR_KEY, key_cnt+1;
     - otherwise → IDLE.
  4. CS=1, RW=0, current state not in {LOAD, RD, RD_DONE} → LOAD. msg_cnt, key_cnt and out_cnt are cleared.
  5. CS=1, RW=0, current state in {LOAD, RD}:
     - out_cnt<WORDS → RD, out_cnt+1;
     - otherwise → RD_DONE.
  6. CS=1, RW=0, state RD_DONE → RD_DONE (no further strobes).
- Back-to-back strobes: consecutive selected write cycles produce one strobe per cycle with no gaps.
- Switching adress mid-burst moves directly between WR_MSG and WR_KEY. Each counter keeps its own progress.
- Write after read (RW 0→1 with CS held): follows rules 2/3. The next read burst re-enters LOAD.
- A read burst always starts with exactly one load cycle, followed by up to WORDS shift_out cycles.
- Partial bursts are legal. The counters only limit over-run; they do not require full blocks before a load.

Decomposition:
- Package fsm_interface_pkg:
  - state enum state_t {IDLE, WR_MSG, WR_KEY, LOAD, RD, RD_DONE}, one-hot encoded;
  - default WORDS constant;
  - counter width helper.
- One optional sub-module, sat_counter (saturating up-counter with clear, width and limit parameters), instantiated three times. Everything else stays in fsm_interface.

Test Plan:
1. Reset held 1 cycle, CS=0 → all outputs 0, state IDLE; RW/adress driven X causes no X on outputs.
2. CS=1, RW=1, adress=0 for 5 cycles → shift_in_message high exactly 5 cycles, starting one cycle after CS rises; no other output asserts.
3. Continue with adress=1 for 5 cycles → shift_in_message drops and shift_in_key is high exactly 5 cycles with no gap.
4. Then RW=0 for 7 cycles → load high 1 cycle, then shift_out high 6 cycles; CS=0 → all outputs 0 next cycle.
5. 20 consecutive message writes (WORDS=16) → 16 shift_in_message cycles, then outputs 0 for the remaining 4.
6. 20 read cycles → 1 load + 16 shift_out, then 0 in RD_DONE. Asserting reset during shift_out → all outputs 0 the cycle after reset is sampled.
